// File: rtl/ffsr_pulse_counter_array.sv
// Multi-channel pulse-driven up/down counter array.
// Each channel has a registered count, at_max/at_zero flags and a one-cycle threshold fire pulse.
module ffsr_pulse_counter_array #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 3,
    parameter bit SATURATE   = 1'b1,
    parameter int THRESH     = 7,
    parameter bit FIRE_CLEAR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCH-1:0]         inc,
    input  logic [NCH-1:0]         dec,
    input  logic [NCH-1:0]         clr,
    output logic [NCH*WIDTH-1:0]   out,
    output logic [NCH-1:0]         at_max,
    output logic [NCH-1:0]         at_zero,
    output logic [NCH-1:0]         fire
);

    localparam int MAXI = (1 << WIDTH) - 1;
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] TH_M1 = WIDTH'(THRESH - 1);

    if (THRESH < 1 || THRESH > MAXI) begin : g_bad_thresh
        $error("THRESH must lie in 1..2^WIDTH-1");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic             max_q;
        logic             zero_q;
        logic             fire_q;
        logic             fire_d;

        always_comb begin
            cnt_d  = cnt_q;
            fire_d = 1'b0;
            priority case (1'b1)
                !en: ;
                clr[i]: cnt_d = '0;
                inc[i] && !dec[i]: begin
                    if (cnt_q == MAX)
                        cnt_d = SATURATE ? MAX : '0;
                    else
                        cnt_d = cnt_q + 1'b1;
                    // Only an inc landing exactly on THRESH fires; wraps land on 0.
                    if (cnt_q == TH_M1) begin
                        fire_d = 1'b1;
                        if (FIRE_CLEAR)
                            cnt_d = '0;
                    end
                end
                dec[i] && !inc[i]: begin
                    if (cnt_q == '0)
                        cnt_d = SATURATE ? '0 : MAX;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q  <= '0;
                max_q  <= 1'b0;
                zero_q <= 1'b1;
                fire_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                max_q  <= (cnt_d == MAX);
                zero_q <= (cnt_d == '0);
                fire_q <= fire_d;
            end
        end

        assign out[i*WIDTH +: WIDTH] = cnt_q;
        assign at_max[i]             = max_q;
        assign at_zero[i]            = zero_q;
        assign fire[i]               = fire_q;
    end

endmodule

// File: tb/tb_ffsr_pulse_counter_array.sv
// Directed bench for ffsr_pulse_counter_array: default, wrapping
// and fire-clear variants share one stimulus stream.
module tb_ffsr_pulse_counter_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  inc, dec, clr;

    logic [11:0] out_d, out_w, out_f;
    logic [3:0]  max_d, max_w, max_f;
    logic [3:0]  zero_d, zero_w, zero_f;
    logic [3:0]  fire_d, fire_w, fire_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ffsr_pulse_counter_array u_def (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .out(out_d), .at_max(max_d), .at_zero(zero_d), .fire(fire_d)
    );

    ffsr_pulse_counter_array #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .out(out_w), .at_max(max_w), .at_zero(zero_w), .fire(fire_w)
    );

    ffsr_pulse_counter_array #(.THRESH(5), .FIRE_CLEAR(1'b1)) u_fc (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .out(out_f), .at_max(max_f), .at_zero(zero_f), .fire(fire_f)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1;
        inc = 4'hF; dec = 4'h0; clr = 4'h0;

        // reset overrides inc
        repeat (3) tick();
        chk("rst_out",  out_d,  32'h0);
        chk("rst_zero", zero_d, 32'hF);
        chk("rst_max",  max_d,  32'h0);
        chk("rst_fire", fire_d, 32'h0);

        rst = 1'b1; inc = 4'h1;
        repeat (2) tick();
        chk("two_inc", out_d[2:0], 32'd2);
        rst = 1'b0;
        tick();
        chk("mid_rst", out_d[2:0], 32'd0);
        rst = 1'b1;

        // saturating up
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("up_cnt",  out_d[2:0], (k < 7) ? k : 7);
            chk("up_max",  max_d[0],   (k >= 7) ? 1 : 0);
            chk("up_fire", fire_d[0],  (k == 7) ? 1 : 0);
        end

        // saturating down
        inc = 4'h0; dec = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("dn_cnt",  out_d[2:0], (k < 7) ? 7 - k : 0);
            chk("dn_zero", zero_d[0],  (k >= 7) ? 1 : 0);
            chk("dn_fire", fire_d[0],  32'h0);
        end

        // priority on ch1
        dec = 4'h0; inc = 4'h2;
        repeat (3) tick();
        chk("ch1_3", out_d[5:3], 32'd3);
        dec = 4'h2;
        tick();
        chk("incdec_hold", out_d[5:3], 32'd3);
        dec = 4'h0; clr = 4'h2;
        tick();
        chk("clr_wins", out_d[5:3], 32'd0);
        clr = 4'h0;
        repeat (2) tick();
        chk("ch1_2", out_d[5:3], 32'd2);
        en = 1'b0; inc = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("en_hold", out_d,  32'h010);
            chk("en_fire", fire_d, 32'h0);
        end
        en = 1'b1; inc = 4'h0;

        // wrap on ch2
        rst = 1'b0;
        tick();
        rst = 1'b1; inc = 4'h4;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("w_up",   out_w[8:6], k);
            chk("w_fire", fire_w[2],  (k == 7) ? 1 : 0);
        end
        chk("w_max7", max_w[2], 32'h1);
        tick();
        chk("w_wrap0",  out_w[8:6], 32'd0);
        chk("w_nofire", fire_w[2],  32'h0);
        chk("w_zero",   zero_w[2],  32'h1);
        chk("w_max0",   max_w[2],   32'h0);
        inc = 4'h0; dec = 4'h4;
        tick();
        chk("w_wrap7", out_w[8:6], 32'd7);
        chk("w_max",   max_w[2],   32'h1);
        chk("w_nz",    zero_w[2],  32'h0);

        // fire-clear on ch3, ch0 saturating down alongside
        rst = 1'b0; dec = 4'h0;
        tick();
        rst = 1'b1; inc = 4'h8; dec = 4'h1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("fc_cnt",  out_f[11:9], (k % 5 == 0) ? 0 : k % 5);
            chk("fc_fire", fire_f[3],   (k % 5 == 0) ? 1 : 0);
            chk("fc_zero", zero_f[3],   (k % 5 == 0) ? 1 : 0);
            chk("fc_max",  max_f[3],    32'h0);
            chk("fc_ch0",  out_f[2:0],  32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
